pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, carry-pipelined lookahead adder/subtractor with valid/ready flow control.
//  - Operands are split into STAGES equal chunks; chunk k is added in pipeline stage k.
//  - Each chunk uses 4-bit carry-lookahead groups. Carry is registered between stages.
//  - Serves as the datapath adder in wide ALU and accumulator paths where a single-cycle
//    WIDTH-bit CLA misses timing; supports backpressure from the consumer.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of 4*STAGES
//  STAGES  4   pipeline depth = number of chunks; CW = WIDTH/STAGES bits per chunk
// PORTS
//  clk        input   1      single clock, all state updates on rising edge
//  reset      input   1      synchronous, active-high reset
//  in_valid   input   1      a/b/c_in/sub hold a valid operation
//  in_ready   output  1      block accepts operation this cycle (in_valid & in_ready)
//  a          input   WIDTH  operand A (unsigned or two's complement)
//  b          input   WIDTH  operand B
//  c_in       input   1      carry in (add mode only)
//  sub        input   1      0: s = a + b + c_in ; 1: s = a - b (= a + ~b + 1, c_in ignored)
//  out_valid  output  1      s/c_out/ovf hold a completed result
//  out_ready  input   1      consumer accepts result (out_valid & out_ready)
//  s          output  WIDTH  sum/difference, WIDTH LSBs
//  c_out      output  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        output  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: all stage valid bits clear; out_valid=0, s=0, c_out=0, ovf=0; in_ready=1 the
//    cycle after reset deasserts. Reset mid-operation discards all in-flight results.
//  - Stage 0 at accept: b' = sub ? ~b : b; cin0 = sub ? 1 : c_in. Chunk 0 summed with cin0;
//    result chunk, carry, and unprocessed a/b' chunks registered.
//  - Stage k (1..STAGES-1): adds chunk k using registered carry from stage k-1; earlier sum
//    chunks skew forward unchanged. Final stage registers s, c_out, ovf.
//  - Chunk adder: CW/4 CLA groups, each g=a&b, p=a|b, group carries by full lookahead;
//    group carry-outs rippled within the chunk; sum = a^b^carry.
//  - Latency: STAGES cycles from accept to out_valid with no stall; throughput 1 op/cycle.
//  - Flow control: stage k loads when its register is empty or its content advances this
//    cycle. ready[STAGES-1] = ~valid[STAGES-1] | out_ready;
//    ready[k] = ~valid[k] | ready[k+1]; in_ready = ready[0]. Full pipeline with out_ready=1
//    accepts and retires in the same cycle.
//  - Stall: out_valid=1 & out_ready=0 holds s/c_out/ovf stable; no bubble collapse loses data.
//  - in_valid & ~in_ready: inputs ignored, no state change; producer must hold.
//  - Ordering strictly FIFO; no operation reordered, dropped or duplicated.
//  - Widths: all arithmetic modulo 2^WIDTH; c_out is bit WIDTH of the true sum.
//  - STAGES=1 degenerates to a single registered CLA adder with the same handshake.
//  - Elaboration error if WIDTH % (4*STAGES) != 0 or STAGES < 1.
// STRUCTURE
//  - Package cla_pkg: CLA_GROUP = 4 localparam; function cla_carries(g,p,cin) returning
//    the 4 group-internal carries and group carry-out; typedef of per-stage
//    record {valid, carry, sum chunks, pending a/b chunks} parametrised by width at use.
//  - Sub-module cla_chunk #(CW): combinational CW-bit adder of CW/4 lookahead groups,
//    ports a, b, c_in, s, c_out, c_msb (carry into chunk MSB, used by final stage for ovf).
//  - Top: generate loop of STAGES cla_chunk instances plus stage registers and ready chain.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1 Reset held 2 cycles then released -> out_valid=0, s=0, in_ready=1; no output before 4 cycles.
//  2 a=32'hFFFF_FFFF, b=1, c_in=0, sub=0, out_ready=1 -> 4 cycles later s=0, c_out=1, ovf=0
//    (carry crosses all chunk boundaries).
//  3 sub=1, a=5, b=7 -> s=32'hFFFF_FFFE, c_out=0, ovf=0; a=32'h8000_0000, b=1 -> s=32'h7FFF_FFFF,
//    c_out=1, ovf=1.
//  4 Back-to-back 100 random ops, out_ready=1 -> one result per cycle, in order, all match model.
//  5 out_ready=0 for 10 cycles while in_valid=1 -> exactly 4 accepted, in_ready=0 afterward,
//    s held stable; release -> 4 results in order, then accepts resume.
//  6 Reset asserted with 3 ops in flight -> next cycle out_valid=0; no stale result ever emitted.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: group size and the 4-bit lookahead carry function.
package cla_pkg;

    localparam int unsigned CLA_GROUP = 4;

    // Returns {group carry-out, carry into bit 3, bit 2, bit 1, bit 0}.
    function automatic logic [CLA_GROUP:0] cla_carries(
        input logic [CLA_GROUP-1:0] g,
        input logic [CLA_GROUP-1:0] p,
        input logic                 cin
    );
        logic [CLA_GROUP:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational CW-bit adder built from 4-bit lookahead groups with rippled group carries.
module cla_chunk
    import cla_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          c_in,
    output logic [CW-1:0] s,
    output logic          c_out,
    output logic          c_msb
);
    localparam int unsigned NG = CW / CLA_GROUP;

    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW-1:0] c;
    logic [NG:0]   gc;

    assign g     = a & b;
    assign p     = a | b;
    assign gc[0] = c_in;

    for (genvar i = 0; i < NG; i++) begin : g_grp
        logic [CLA_GROUP:0] cc;
        assign cc                          = cla_carries(g[i*CLA_GROUP +: CLA_GROUP],
                                                         p[i*CLA_GROUP +: CLA_GROUP], gc[i]);
        assign c[i*CLA_GROUP +: CLA_GROUP] = cc[CLA_GROUP-1:0];
        assign gc[i+1]                     = cc[CLA_GROUP];
    end

    assign s     = a ^ b ^ c;
    assign c_out = gc[NG];
    assign c_msb = c[CW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Carry-pipelined CLA adder/subtractor: chunk k is summed in stage k, valid/ready flow control.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int unsigned CW = WIDTH / STAGES;

    if ((STAGES < 1) || ((WIDTH % (CLA_GROUP * STAGES)) != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES and STAGES >= 1");
    end

    // Per-stage record: finished low sum chunks, pending high a/b' chunks, carry out.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t            stg_q [STAGES];
    stage_t            stg_d [STAGES];
    logic [STAGES-1:0] ready_c;

    // Backpressure chain from the consumer toward the producer.
    always_comb begin
        ready_c             = '0;
        ready_c[STAGES-1]   = ~stg_q[STAGES-1].valid | out_ready;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            ready_c[i] = ~stg_q[i].valid | ready_c[i+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        prev;
        stage_t        d;
        logic [CW-1:0] ch_s;
        logic          ch_cout;
        logic          ch_cmsb;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; carry-in forced high, c_in ignored.
            always_comb begin
                prev       = '0;
                prev.valid = in_valid;
                prev.carry = sub | c_in;
                prev.a     = a;
                prev.b     = sub ? ~b : b;
            end
        end else begin : g_next
            assign prev = stg_q[k-1];
        end

        cla_chunk #(.CW(CW)) u_chunk (
            .a     (prev.a[k*CW +: CW]),
            .b     (prev.b[k*CW +: CW]),
            .c_in  (prev.carry),
            .s     (ch_s),
            .c_out (ch_cout),
            .c_msb (ch_cmsb)
        );

        always_comb begin
            d                   = prev;
            d.sum[k*CW +: CW]   = ch_s;
            d.carry             = ch_cout;
            d.ovf               = ch_cmsb ^ ch_cout;
        end

        assign stg_d[k] = d;
    end

    // Payload only loads with a valid op so a drained output keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (ready_c[i]) begin
                    if (stg_d[i].valid) begin
                        stg_q[i] <= stg_d[i];
                    end else begin
                        stg_q[i].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = ready_c[0];
    assign out_valid = stg_q[STAGES-1].valid;
    assign s         = stg_q[STAGES-1].sum;
    assign c_out     = stg_q[STAGES-1].carry;
    assign ovf       = stg_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: arithmetic reference model, FIFO scoreboard, directed vectors.
module tb_pipelined_cla_adder;
    localparam int unsigned W  = 32;
    localparam int unsigned ST = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    pipelined_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        bit           lit;
        logic [W-1:0] ls;
        logic         lc;
        logic         lo;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           attempts = 0;
    bit           lit_en   = 0;
    logic [W-1:0] lit_s    = '0;
    logic         lit_c    = 1'b0;
    logic         lit_o    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: true (W+1)-bit sum; overflow when like-signed operands give a differently signed result.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        exp_t         e;
        logic [W-1:0] bx;
        logic         ci;
        logic [W:0]   full;
        bx    = ms ? ~mb : mb;
        ci    = ms ? 1'b1 : mc;
        full  = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, ci};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.o   = (ma[W-1] == bx[W-1]) && (e.s[W-1] != ma[W-1]);
        e.lit = 1'b0;
        e.ls  = '0;
        e.lc  = 1'b0;
        e.lo  = 1'b0;
        return e;
    endfunction

    bit           prev_stall = 0;
    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         prev_o;

    // Scoreboard: handshakes observed mid-cycle, when inputs and ready are settled.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_hold", {31'b0, prev_c, prev_s}, {31'b0, c_out, s});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("model_result", {30'b0, e.o, e.c, e.s}, {30'b0, ovf, c_out, s});
                    if (e.lit) check("literal_result", {30'b0, ovf, c_out, s}, {30'b0, e.lo, e.lc, e.ls});
                end
            end
            if (in_valid && in_ready) begin
                e     = model(a, b, c_in, sub);
                e.lit = lit_en;
                e.ls  = lit_s;
                e.lc  = lit_c;
                e.lo  = lit_o;
                exp_q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = s;
            prev_c     = c_out;
            prev_o     = ovf;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input bit le, input logic [W-1:0] ls,
                        input logic lc, input logic lo);
        bit acc;
        int guard;
        lit_en   = le;
        lit_s    = ls;
        lit_c    = lc;
        lit_o    = lo;
        a        = ta;
        b        = tb;
        c_in     = tc;
        sub      = ts;
        in_valid = 1'b1;
        acc      = 0;
        guard    = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            attempts++;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        lit_en   = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int  lat;
        int  att0;
        int  acc_n;
        bit  hit;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_s", 64'(s), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Carry ripples across every chunk boundary; also measures accept-to-valid latency.
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 32'h0, 1'b1, 1'b0);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (out_valid && lat == 0) lat = n;
        end
        check("latency", 64'(lat), 64'(ST));
        drain();

        send(32'd5, 32'd7, 1'b0, 1'b1, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1, 32'h2345_678A, 1'b0, 1'b0);
        send(32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h0, 1'b1, 1'b0);
        drain();

        att0 = attempts;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 0, '0, 1'b0, 1'b0);
        end
        check("b2b_one_per_cycle", 64'(attempts - att0), 64'(100));
        drain();

        // Backpressure: full pipeline must hold and then resume in order.
        out_ready = 1'b0;
        acc_n     = 0;
        a         = $urandom;
        b         = $urandom;
        c_in      = 1'b1;
        sub       = 1'b0;
        in_valid  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            hit = in_ready;
            if (hit) acc_n++;
            @(posedge clk);
            #1;
            if (hit) begin
                a    = $urandom;
                b    = $urandom;
                sub  = 1'($urandom_range(0, 1));
                c_in = 1'($urandom_range(0, 1));
            end
        end
        check("stall_accepts", 64'(acc_n), 64'(ST));
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        acc_n     = 0;
        repeat (4) begin
            @(negedge clk);
            hit = in_ready;
            if (hit) acc_n++;
            @(posedge clk);
            #1;
            if (hit) begin
                a = $urandom;
                b = $urandom;
            end
        end
        check("resume_accepts", 64'(acc_n), 64'(4));
        in_valid = 1'b0;
        drain();

        // Reset with ops in flight discards them.
        send(32'h1, 32'h2, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        send(32'h3, 32'h4, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        send(32'h5, 32'h6, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_s", 64'(s), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
